i2c_bit_timer: RTL

- Bit-slot scheduler for the I2C master driving the MPU-6050.
- Divides the system clock into four equal quarter-phases per SCL bit and sequences the SCL pull-down pattern for DATA/START/STOP/RSTART slots.
- Issues phase and sample strobes to the I2C byte FSM.
- Handles slave clock stretching; sits between the byte-level FSM and the open-drain SCL pad.

---
 rtl/i2c_bit_timer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_bit_timer.sv
// I2C SCL bit-slot sequencer: four quarter-phases per bit, SCL pull-down pattern, clock stretching.
// Define I2C_STRETCH_TIMEOUT_EN to add the stretch watchdog (STRETCH_LIMIT, stretch_timeout).
module i2c_bit_timer #(
    parameter logic [26:0] DIVISOR = 27'd1000
`ifdef I2C_STRETCH_TIMEOUT_EN
    ,
    parameter logic [26:0] STRETCH_LIMIT = 27'd100000
`endif
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       bit_start,
    input  logic [1:0] bit_kind,
    input  logic       scl_in,
    output logic       ready,
    output logic       busy,
    output logic [1:0] phase,
    output logic       phase_tick,
    output logic       sample_tick,
    output logic       bit_done,
    output logic       scl_oe,
`ifdef I2C_STRETCH_TIMEOUT_EN
    output logic       stretch_timeout,
`endif
    output logic       stretching
);
    localparam logic [26:0] QUARTER = DIVISOR / 27'd4;
    localparam logic [26:0] Q_LAST  = QUARTER - 27'd1;

    localparam logic [1:0] K_DATA   = 2'd0;
    localparam logic [1:0] K_START  = 2'd1;
    localparam logic [1:0] K_RSTART = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_PH0, S_PH1, S_PH2, S_PH3} state_t;

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic [1:0]  kind_q, kind_d;
    logic        scl_meta_q, scl_meta_d;
    logic        scl_sync_q, scl_sync_d;
    logic        phase_tick_q, phase_tick_d;
    logic        sample_tick_q, sample_tick_d;
    logic        scl_oe_q, scl_oe_d;
    logic        last_cycle;
    logic        hold;
    logic        start_slot;
    logic        timeout_hit;
    state_t      next_phase_state;

    // SCL pull-down for a given slot kind and quarter phase
    function automatic logic oe_pattern(input logic [1:0] kind, input logic [1:0] ph);
        logic oe;
        case (kind)
            K_DATA:  oe = ~ph[1];
            K_START: oe = 1'b0;
            default: oe = (ph == 2'd0);
        endcase
        return oe;
    endfunction

    always_comb begin
        case (state_q)
            S_PH1:   phase = 2'd1;
            S_PH2:   phase = 2'd2;
            S_PH3:   phase = 2'd3;
            default: phase = 2'd0;
        endcase
    end

    always_comb begin
        case (state_q)
            S_PH0:   next_phase_state = S_PH1;
            S_PH1:   next_phase_state = S_PH2;
            default: next_phase_state = S_PH3;
        endcase
    end

    assign last_cycle = (state_q == S_PH3) && (cnt_q == Q_LAST);
    assign ready      = (state_q == S_IDLE) || last_cycle;
    assign start_slot = bit_start && ready;
    assign busy       = (state_q != S_IDLE);
    // Only slots that release SCL in PH2 can be stretched by the slave
    assign hold       = (state_q == S_PH2) && ((kind_q == K_DATA) || (kind_q == K_RSTART))
                        && !scl_sync_q;
    assign stretching = hold;
    assign bit_done   = last_cycle || timeout_hit;
    assign phase_tick  = phase_tick_q;
    assign sample_tick = sample_tick_q;
    assign scl_oe      = scl_oe_q;

`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [26:0] scnt_q, scnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        scnt_d      = hold ? (scnt_q + 27'd1) : 27'd0;
        timeout_hit = hold && (scnt_q == STRETCH_LIMIT - 27'd1);
        timeout_d   = timeout_q;
        if (start_slot) begin
            timeout_d = 1'b0;
        end else if (timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            scnt_q    <= 27'd0;
            timeout_q <= 1'b0;
        end else begin
            scnt_q    <= scnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stretch_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kind_d        = kind_q;
        phase_tick_d  = 1'b0;
        sample_tick_d = 1'b0;
        scl_oe_d      = scl_oe_q;
        scl_meta_d    = scl_in;
        scl_sync_d    = scl_meta_q;

        case (state_q)
            S_IDLE: cnt_d = 27'd0;
            S_PH3: begin
                if (last_cycle) begin
                    state_d  = S_IDLE;
                    cnt_d    = 27'd0;
                    scl_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            default: begin
                if (timeout_hit) begin
                    state_d  = S_IDLE;
                    cnt_d    = 27'd0;
                    scl_oe_d = 1'b0;
                end else if (hold) begin
                    cnt_d = 27'd0;
                end else if (cnt_q == Q_LAST) begin
                    cnt_d         = 27'd0;
                    state_d       = next_phase_state;
                    phase_tick_d  = 1'b1;
                    sample_tick_d = (state_q == S_PH2);
                    scl_oe_d      = oe_pattern(kind_q, phase + 2'd1);
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
        endcase

        // An accepted request wins from IDLE and from the PH3 last cycle alike
        if (start_slot) begin
            state_d       = S_PH0;
            cnt_d         = 27'd0;
            kind_d        = bit_kind;
            phase_tick_d  = 1'b1;
            sample_tick_d = 1'b0;
            scl_oe_d      = oe_pattern(bit_kind, 2'd0);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 27'd0;
            kind_q        <= K_DATA;
            scl_meta_q    <= 1'b1;
            scl_sync_q    <= 1'b1;
            phase_tick_q  <= 1'b0;
            sample_tick_q <= 1'b0;
            scl_oe_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            kind_q        <= kind_d;
            scl_meta_q    <= scl_meta_d;
            scl_sync_q    <= scl_sync_d;
            phase_tick_q  <= phase_tick_d;
            sample_tick_q <= sample_tick_d;
            scl_oe_q      <= scl_oe_d;
        end
    end
endmodule
